// File: rtl/msg_pkg.sv
// msg_pkg: shared FSM state type and idle word constant for msg_queue
package msg_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} tx_state_t;
  localparam logic [63:0] IDLE_WORD_ALL = '1;
endpackage

// File: rtl/msg_fifo.sv
// msg_fifo: circular word buffer with registered count, full/empty and sticky overflow
module msg_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d, do_push, do_pop;
  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_push = push && !clear && (!full || pop);
    do_pop = pop && !clear;
    head_d = clear ? '0 : head_q + AW'(do_pop);
    tail_d = clear ? '0 : tail_q + AW'(do_push);
    count_d = clear ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    overflow_d = !clear && (overflow_q || (push && full && !pop));
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[tail_q] <= data;
  assign head = mem_q[head_q];
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/msg_queue.sv
// msg_queue: buffers message words and hands them to the UART with a start-pulse/ready handshake
module msg_queue import msg_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_WORD = IDLE_WORD_ALL[DATA_W-1:0],
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  input  logic              transmit_ready,
  output logic              tx_ctrl,
  output logic [DATA_W-1:0] tx_byte,
  output logic              blue,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow
);
  tx_state_t state_q, state_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d, head;
  logic pop;
  msg_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .nRst(nRst),
    .push(push),
    .pop(pop),
    .clear(clear),
    .data(data),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );
  // A flush during ISSUE already emptied the queue, so the pop must not happen.
  assign pop = state_q == ISSUE && !clear;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = !empty && transmit_ready ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  state_d = transmit_ready ? WAIT_ACK : WAIT_DONE;
      WAIT_DONE: state_d = transmit_ready ? IDLE : WAIT_DONE;
    endcase
    tx_byte_d = state_q == IDLE && state_d == ISSUE ? head : state_d == IDLE ? IDLE_WORD : tx_byte_q;
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state_q <= IDLE;
      tx_byte_q <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  assign tx_ctrl = state_q == ISSUE;
  assign tx_byte = tx_byte_q;
  assign blue = state_q != IDLE;
endmodule

// File: doc/msg_queue.md
# msg_queue

Parametrised message buffer between the keypad/letter encoder and the UART transmitter. Accepts DATA_W-bit message words on a one-cycle push strobe, stores up to DEPTH of them in order, and hands them one at a time to the transmitter using a start-pulse/ready handshake. Adds occupancy status, overflow detection and a synchronous flush. Sits in the wireless transmit path, driving the transmitter's start and data inputs and the blue "sending" LED.

## Interface
- DATA_W, 8: message word width.
- DEPTH, 4: queue entries; power of two, at least 2.
- IDLE_WORD, all ones: value on tx_byte while nothing is in flight.
- CW = $clog2(DEPTH+1): derived count width, not overridable.

Clock is clk. Reset is nRst: asynchronous, active-low.

- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- push  in  1  one-cycle strobe: enqueue data.
- data  in  DATA_W  word to enqueue, sampled when push=1.
- clear  in  1  synchronous flush of queued words; clears overflow.
- transmit_ready  in  1  transmitter idle and able to accept a word.
- tx_ctrl  out  1  one-cycle start pulse to the transmitter.
- tx_byte  out  DATA_W  word presented to the transmitter.
- blue  out  1  high while a word is in flight (state not IDLE).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  number of queued words, excluding the word in flight.
- overflow  out  1  sticky flag: a push was dropped.

## Operation
- The queue is a circular buffer with head and tail pointers of width $clog2(DEPTH) that wrap from DEPTH-1 to 0. count is registered.
- A push when not full writes data at the tail. A push when full with no pop in the same cycle is dropped and sets overflow.
- A push and a pop in the same cycle, including when full, are both honoured and count is unchanged. A pop never coincides with empty.
- The transmit FSM has four states:
  - IDLE: tx_ctrl=0, tx_byte=IDLE_WORD, blue=0. Goes to ISSUE when !empty && transmit_ready.
  - ISSUE: lasts exactly one cycle. tx_ctrl=1; tx_byte register loaded with the head on entry. The head is popped at the exit edge. Always goes to WAIT_ACK.
  - WAIT_ACK: tx_ctrl=0, tx_byte held. Goes to WAIT_DONE when transmit_ready=0.
  - WAIT_DONE: tx_byte held. Goes to IDLE when transmit_ready=1.
- clear empties the queue: pointers and count to 0, overflow to 0. It does not abort the word in flight; the FSM completes its handshake.
- clear together with push: clear wins and the push is discarded. clear during ISSUE: the pop is suppressed, since the queue is already flushed.
- overflow stays set until clear or reset.

## Timing
- Reset values: tx_ctrl=0, tx_byte=IDLE_WORD, blue=0, full=0, empty=1, count=0, overflow=0, state IDLE, pointers 0.
- A push sampled at edge 0 gives empty=0 and count=1 after edge 0.
- If transmit_ready=1, ISSUE is entered at edge 1 and tx_ctrl is high for the cycle after edge 1. count decrements at edge 2.
- tx_byte is valid from edge 1 and holds until the FSM returns to IDLE.
- Back-to-back words are separated by at least one IDLE cycle after transmit_ready returns high.
- Reset mid-transaction forces all outputs to their reset values immediately, with no handshake completion.
- All outputs are registered or decoded from registered state only; there is no combinational path from push or data to any output.

## Structure
- Package msg_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, ISSUE, WAIT_ACK, WAIT_DONE};
  - the default IDLE_WORD constant.
- Sub-module msg_fifo (DATA_W, DEPTH) contains the storage, pointers, count, full, empty and overflow. Its inputs are push, pop, clear and data; its output is the head word.
- The top level contains the FSM, the tx_byte register and the blue decode.

## Test plan
- Reset then idle, transmit_ready=1 -> tx_byte=8'hFF, tx_ctrl=0, empty=1, count=0 for 10 cycles.
- Push 8'h41, transmit_ready=1; transmitter model drops ready 1 cycle after tx_ctrl and raises it 5 cycles later -> single tx_ctrl pulse 2 edges after push, tx_byte=8'h41 until IDLE, blue high throughout, count returns to 0.
- With transmit_ready=0, push 8'h41, 8'h42, 8'h43, 8'h44, 8'h45 (DEPTH=4) -> full=1 after the 4th push, overflow=1 after the 5th. Release ready -> words transmitted in order 41, 42, 43, 44; 45 never appears.
- Full queue with push and ISSUE-pop in the same cycle -> count stays 4, the new word is transmitted last, overflow unchanged.
- Queue holding 3 words, one in flight; assert clear -> count=0, overflow=0, in-flight word completes its handshake, no further tx_ctrl.
- Assert nRst low during WAIT_DONE -> outputs go to reset values asynchronously, with no tx_ctrl pulse after release until a new push.
